layer_serializer: RTL and testbench
===================================

// Module: layer_serializer
// PURPOSE
//  Converts one layer's parallel output vector (NEURON_NUM words) into a word-serial stream for
//  the next layer's input. It is the generalised inter-layer pipeline stage between layerN and
//  layerN+1. Adds valid/ready backpressure, a one-vector skid buffer, a last-beat marker, an
//  element index, selectable element order and a sticky overflow flag.
// PARAMETERS
//  NEURON_NUM  30  words per input vector (>=1)
//  DATA_WIDTH  16  bits per word
//  LSB_FIRST   1   1: word 0 (bits DATA_WIDTH-1:0) is sent first; 0: word NEURON_NUM-1 is sent first
//  IDX_WIDTH   $clog2(NEURON_NUM) (min 1)  width of out_index
// PORTS
//  clk        in   1                      rising-edge clock
//  rst        in   1                      synchronous, active-high reset
//  in_data    in   NEURON_NUM*DATA_WIDTH  parallel layer output vector
//  in_valid   in   1                      in_data valid
//  in_ready   out  1                      block can accept a vector this cycle
//  out_data   out  DATA_WIDTH             current serial word
//  out_valid  out  1                      out_data valid
//  out_ready  in   1                      downstream accepts the word
//  out_last   out  1                      current word is the final word of its vector
//  out_index  out  IDX_WIDTH              position of the current word in its vector (always the original word number)
//  busy       out  1                      active or pending vector present
//  overflow   out  1                      sticky: in_valid seen while in_ready=0
// BEHAVIOUR
//  Storage: ACTIVE register (vector being sent, with beat counter) and PENDING register (one waiting vector, flag pend_v).
//  FSM states:
//   - IDLE -> SEND on accept.
//   - SEND -> IDLE on the last-beat handshake if no vector is pending and none is accepted in that cycle.
//   - Otherwise SEND stays in SEND.
//  Handshakes:
//   - in_ready = !pend_v (combinational from state). Accept = in_valid & in_ready.
//   - Out beat = out_valid & out_ready.
//   - out_data, out_valid, out_last and out_index are registered. They stay stable while out_valid=1 and out_ready=0.
//  Accept routing:
//   - Accepted vector goes to ACTIVE if the block is in IDLE, or if the last beat completes in the same cycle.
//   - Otherwise it goes to PENDING.
//  Latency and throughput:
//   - First word: out_valid rises on the cycle after accept.
//   - Exactly NEURON_NUM beats per vector.
//   - With out_ready held at 1 there is one word per cycle and no bubbles, including across vector boundaries.
//  Vector handoff: on the last-beat handshake with pend_v=1, PENDING moves to ACTIVE and pend_v clears. The first word of the new vector is presented on the next cycle.
//  Word order: out_index counts 0..N-1 when LSB_FIRST=1 and N-1..0 when LSB_FIRST=0. out_last=1 on the final beat in both modes.
//  Overflow: in_valid=1 while in_ready=0 sets overflow=1. The vector is not captured. overflow clears only on rst.
//  Reset (any cycle, including mid-vector): FSM=IDLE, pend_v=0, out_valid=0, out_last=0, out_index=0, out_data=0, busy=0, overflow=0. in_ready=1 in the cycle after rst deasserts. A partial vector is discarded.
//  NEURON_NUM=1: every beat has out_last=1 and out_index=0.
//  No arithmetic on data. Words pass bit-exact.
// TESTING (NEURON_NUM=4, DATA_WIDTH=8 unless noted)
//  1. in_data=32'h44332211 accepted, out_ready=1 -> out_data 11,22,33,44 on four consecutive cycles. out_index=0..3. out_last only on 44. Then out_valid=0.
//  2. LSB_FIRST=0, same vector -> out_data 44,33,22,11. out_index=3,2,1,0. out_last on 11.
//  3. Two vectors back-to-back (A=32'h04030201, then B=32'h08070605 while A is streaming), out_ready=1 -> 8 contiguous beats 01..08. No gap. out_last on 04 and 08.
//  4. Backpressure: out_ready=0 for 5 cycles during beat 2 -> out_data=8'h22 held stable, no beats lost or duplicated.
//  5. Overflow: ACTIVE and PENDING full, out_ready=0, third in_valid -> in_ready=0, overflow=1 and stays 1. Third vector is never output.
//  6. rst pulsed during beat 2 of 4 -> next cycle out_valid=0, busy=0, overflow=0. A new vector then streams cleanly from index 0.

Source files
------------

// File: rtl/layer_serializer.sv
// layer_serializer
//   Turns one layer's parallel output vector (NEURON_NUM words of DATA_WIDTH bits)
//   into a word-serial valid/ready stream for the next layer. One vector is streamed
//   from the ACTIVE register while at most one more waits in PENDING.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_data    parallel input vector, word i at bits [i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid   in_data is valid
//   in_ready   a vector can be accepted this cycle (PENDING is empty)
//   out_data   current serial word (registered)
//   out_valid  out_data is valid (registered)
//   out_ready  downstream accepts the current word
//   out_last   current word is the final beat of its vector (registered)
//   out_index  original word number of the current word (registered)
//   busy       a vector is active or pending
//   overflow   sticky: in_valid was seen while in_ready was low
//
// State | meaning
//   ST_IDLE | nothing being sent, out_valid low
//   ST_SEND | ACTIVE vector being streamed, out_valid high

module layer_serializer #(
  parameter int NEURON_NUM = 30,
  parameter int DATA_WIDTH = 16,
  parameter bit LSB_FIRST  = 1'b1,
  parameter int IDX_WIDTH  = (NEURON_NUM > 1) ? $clog2(NEURON_NUM) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NEURON_NUM*DATA_WIDTH-1:0] in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic [IDX_WIDTH-1:0]             out_index,
  output logic                             busy,
  output logic                             overflow
);

  localparam int VEC_W = NEURON_NUM * DATA_WIDTH;
  localparam logic [IDX_WIDTH-1:0] TOP_IDX   = IDX_WIDTH'(NEURON_NUM - 1);
  localparam logic [IDX_WIDTH-1:0] FIRST_IDX = LSB_FIRST ? '0 : TOP_IDX;
  localparam logic [IDX_WIDTH-1:0] FINAL_IDX = LSB_FIRST ? TOP_IDX : '0;
  localparam bit                   SINGLE    = (NEURON_NUM == 1);

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_e;

  state_e                  state_q, state_d;
  logic [VEC_W-1:0]        active_q, active_d;
  logic [VEC_W-1:0]        pend_q, pend_d;
  logic                    pend_v_q, pend_v_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic [IDX_WIDTH-1:0]    out_index_q, out_index_d;
  logic                    overflow_q, overflow_d;

  logic                    accept;
  logic                    beat;
  logic                    last_beat;
  logic                    load_en;
  logic [VEC_W-1:0]        load_src;
  logic [IDX_WIDTH-1:0]    next_idx;

  function automatic logic [DATA_WIDTH-1:0] word_of(input logic [VEC_W-1:0]     v,
                                                    input logic [IDX_WIDTH-1:0] i);
    return v[int'(i)*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  assign in_ready  = ~pend_v_q;
  assign accept    = in_valid & ~pend_v_q;
  assign beat      = out_valid_q & out_ready;
  assign last_beat = beat & out_last_q;
  assign next_idx  = LSB_FIRST ? (out_index_q + IDX_WIDTH'(1)) : (out_index_q - IDX_WIDTH'(1));

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    pend_d      = pend_q;
    pend_v_d    = pend_v_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_index_d = out_index_q;
    overflow_d  = overflow_q | (in_valid & pend_v_q);
    load_en     = 1'b0;
    load_src    = in_data;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          load_en = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (last_beat) begin
          // PENDING has priority; in_ready is low whenever it is full,
          // so an accept here can only happen with PENDING empty.
          if (pend_v_q) begin
            load_en  = 1'b1;
            load_src = pend_q;
            pend_v_d = 1'b0;
          end else if (accept) begin
            load_en = 1'b1;
          end else begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = ST_IDLE;
          end
        end else begin
          if (beat) begin
            out_index_d = next_idx;
            out_data_d  = word_of(active_q, next_idx);
            out_last_d  = (next_idx == FINAL_IDX);
          end
          if (accept) begin
            pend_d   = in_data;
            pend_v_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Loading ACTIVE presents its first word on the very next cycle.
    if (load_en) begin
      active_d    = load_src;
      out_data_d  = word_of(load_src, FIRST_IDX);
      out_index_d = FIRST_IDX;
      out_last_d  = SINGLE;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      active_q    <= '0;
      pend_q      <= '0;
      pend_v_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_index_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      pend_v_q    <= pend_v_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_index_q <= out_index_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_index = out_index_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q == ST_SEND) | pend_v_q;

endmodule

// File: tb/tb_layer_serializer.sv
module tb_layer_serializer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready_o  [3];
  logic        out_valid_o [3];
  logic        out_last_o  [3];
  logic        busy_o      [3];
  logic        ovf_o       [3];
  logic [7:0]  out_data_o  [3];
  logic [1:0]  out_index_o [3];
  logic        one_index;

  // 0: N=4 LSB first, 1: N=4 MSB first, 2: N=1
  layer_serializer #(.NEURON_NUM(4), .DATA_WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_o[0]),
    .out_data(out_data_o[0]), .out_valid(out_valid_o[0]), .out_ready(out_ready),
    .out_last(out_last_o[0]), .out_index(out_index_o[0]), .busy(busy_o[0]), .overflow(ovf_o[0]));

  layer_serializer #(.NEURON_NUM(4), .DATA_WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_o[1]),
    .out_data(out_data_o[1]), .out_valid(out_valid_o[1]), .out_ready(out_ready),
    .out_last(out_last_o[1]), .out_index(out_index_o[1]), .busy(busy_o[1]), .overflow(ovf_o[1]));

  layer_serializer #(.NEURON_NUM(1), .DATA_WIDTH(8), .LSB_FIRST(1'b1)) u_one (
    .clk(clk), .rst(rst), .in_data(in_data[7:0]), .in_valid(in_valid), .in_ready(in_ready_o[2]),
    .out_data(out_data_o[2]), .out_valid(out_valid_o[2]), .out_ready(out_ready),
    .out_last(out_last_o[2]), .out_index(one_index), .busy(busy_o[2]), .overflow(ovf_o[2]));

  assign out_index_o[2] = {1'b0, one_index};

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a queue of held vectors (front = being sent) and the
  // number of beats already sent from the front vector.
  int          nn    [3];
  bit          lsb_m [3];
  logic [31:0] vq    [3][$];
  int          pos   [3];
  bit          ovf_m [3];

  task automatic model_step();
    bit rdy, bt, acc;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        vq[k].delete();
        pos[k]   = 0;
        ovf_m[k] = 1'b0;
      end else begin
        rdy = (vq[k].size() < 2);
        bt  = (vq[k].size() > 0) && out_ready;
        acc = in_valid && rdy;
        if (in_valid && !rdy) ovf_m[k] = 1'b1;
        if (bt) begin
          pos[k]++;
          if (pos[k] == nn[k]) begin
            void'(vq[k].pop_front());
            pos[k] = 0;
          end
        end
        if (acc) vq[k].push_back((nn[k] == 1) ? {24'h0, in_data[7:0]} : in_data);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int exp_idx(int k);
    return lsb_m[k] ? pos[k] : (nn[k] - 1 - pos[k]);
  endfunction

  function automatic logic [7:0] exp_word(int k);
    logic [31:0] v;
    v = vq[k][0];
    return v[8*exp_idx(k) +: 8];
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (out_valid_o[k] !== 1'b0) begin n_err++; $display("FAIL rst_valid[%0d] got %b exp 0", k, out_valid_o[k]); end
      n_vec++; if (out_last_o[k] !== 1'b0) begin n_err++; $display("FAIL rst_last[%0d] got %b exp 0", k, out_last_o[k]); end
      n_vec++; if (out_index_o[k] !== 2'd0) begin n_err++; $display("FAIL rst_index[%0d] got %0d exp 0", k, out_index_o[k]); end
      n_vec++; if (out_data_o[k] !== 8'h00) begin n_err++; $display("FAIL rst_data[%0d] got %h exp 00", k, out_data_o[k]); end
      n_vec++; if (busy_o[k] !== 1'b0) begin n_err++; $display("FAIL rst_busy[%0d] got %b exp 0", k, busy_o[k]); end
      n_vec++; if (ovf_o[k] !== 1'b0) begin n_err++; $display("FAIL rst_ovf[%0d] got %b exp 0", k, ovf_o[k]); end
      n_vec++; if (in_ready_o[k] !== 1'b1) begin n_err++; $display("FAIL rst_in_ready[%0d] got %b exp 1", k, in_ready_o[k]); end
    end
  endtask

  task automatic test_word_order();
    logic [7:0] w [4];
    w = '{8'h11, 8'h22, 8'h33, 8'h44};
    in_data = 32'h44332211; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      n_vec++; if (out_valid_o[0] !== 1'b1 || out_data_o[0] !== w[b]) begin n_err++; $display("FAIL lsb_word%0d got v=%b d=%h exp v=1 d=%h", b, out_valid_o[0], out_data_o[0], w[b]); end
      n_vec++; if (out_index_o[0] !== 2'(b) || out_last_o[0] !== (b == 3)) begin n_err++; $display("FAIL lsb_idx%0d got i=%0d l=%b exp i=%0d l=%b", b, out_index_o[0], out_last_o[0], b, b == 3); end
      n_vec++; if (out_valid_o[1] !== 1'b1 || out_data_o[1] !== w[3-b]) begin n_err++; $display("FAIL msb_word%0d got v=%b d=%h exp v=1 d=%h", b, out_valid_o[1], out_data_o[1], w[3-b]); end
      n_vec++; if (out_index_o[1] !== 2'(3-b) || out_last_o[1] !== (b == 3)) begin n_err++; $display("FAIL msb_idx%0d got i=%0d l=%b exp i=%0d l=%b", b, out_index_o[1], out_last_o[1], 3-b, b == 3); end
      if (b == 0) begin
        n_vec++; if (out_valid_o[2] !== 1'b1 || out_data_o[2] !== 8'h11 || out_last_o[2] !== 1'b1 || out_index_o[2] !== 2'd0) begin
          n_err++; $display("FAIL one_beat got v=%b d=%h l=%b i=%0d exp v=1 d=11 l=1 i=0", out_valid_o[2], out_data_o[2], out_last_o[2], out_index_o[2]); end
      end else if (b == 1) begin
        n_vec++; if (out_valid_o[2] !== 1'b0) begin n_err++; $display("FAIL one_done got v=%b exp 0", out_valid_o[2]); end
      end
      tick();
    end
    n_vec++; if (out_valid_o[0] !== 1'b0 || out_valid_o[1] !== 1'b0) begin n_err++; $display("FAIL order_end got v=%b/%b exp 0/0", out_valid_o[0], out_valid_o[1]); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_data = 32'h04030201; in_valid = 1'b1;
    tick();
    in_data = 32'h08070605;
    for (int b = 0; b < 8; b++) begin
      if (b == 1) begin
        in_valid = 1'b0;
        n_vec++; if (in_ready_o[0] !== 1'b0) begin n_err++; $display("FAIL b2b_in_ready got %b exp 0", in_ready_o[0]); end
      end
      n_vec++; if (out_valid_o[0] !== 1'b1 || out_data_o[0] !== 8'(b + 1) || out_last_o[0] !== (b == 3 || b == 7)) begin
        n_err++; $display("FAIL b2b_beat%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b", b, out_valid_o[0], out_data_o[0], out_last_o[0], 8'(b + 1), (b == 3 || b == 7)); end
      tick();
    end
    n_vec++; if (out_valid_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin n_err++; $display("FAIL b2b_end got v=%b busy=%b exp 0/0", out_valid_o[0], busy_o[0]); end
  endtask

  task automatic test_backpressure();
    logic [7:0] w [4];
    w = '{8'h11, 8'h22, 8'h33, 8'h44};
    in_data = 32'h44332211; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_vec++; if (out_valid_o[0] !== 1'b1 || out_data_o[0] !== 8'h22 || out_index_o[0] !== 2'd1) begin
        n_err++; $display("FAIL bp_hold%0d got v=%b d=%h i=%0d exp v=1 d=22 i=1", c, out_valid_o[0], out_data_o[0], out_index_o[0]); end
      tick();
    end
    out_ready = 1'b1;
    for (int b = 1; b < 4; b++) begin
      n_vec++; if (out_valid_o[0] !== 1'b1 || out_data_o[0] !== w[b]) begin n_err++; $display("FAIL bp_word%0d got v=%b d=%h exp v=1 d=%h", b, out_valid_o[0], out_data_o[0], w[b]); end
      tick();
    end
    n_vec++; if (out_valid_o[0] !== 1'b0) begin n_err++; $display("FAIL bp_end got v=%b exp 0", out_valid_o[0]); end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    in_data = 32'h04030201; in_valid = 1'b1; tick();
    in_data = 32'h08070605; tick();
    n_vec++; if (in_ready_o[0] !== 1'b0 || ovf_o[0] !== 1'b0) begin n_err++; $display("FAIL ovf_full got rdy=%b ovf=%b exp 0/0", in_ready_o[0], ovf_o[0]); end
    in_data = 32'h0c0b0a09; tick();
    in_valid = 1'b0;
    n_vec++; if (in_ready_o[0] !== 1'b0 || ovf_o[0] !== 1'b1) begin n_err++; $display("FAIL ovf_set got rdy=%b ovf=%b exp 0/1", in_ready_o[0], ovf_o[0]); end
    repeat (3) tick();
    out_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      n_vec++; if (out_valid_o[0] !== 1'b1 || out_data_o[0] !== 8'(b + 1)) begin n_err++; $display("FAIL ovf_drain%0d got v=%b d=%h exp v=1 d=%h", b, out_valid_o[0], out_data_o[0], 8'(b + 1)); end
      tick();
    end
    n_vec++; if (out_valid_o[0] !== 1'b0 || busy_o[0] !== 1'b0 || ovf_o[0] !== 1'b1) begin
      n_err++; $display("FAIL ovf_end got v=%b busy=%b ovf=%b exp 0/0/1", out_valid_o[0], busy_o[0], ovf_o[0]); end
  endtask

  task automatic test_reset_mid();
    in_data = 32'h44332211; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_vec++; if (out_valid_o[k] !== 1'b0 || busy_o[k] !== 1'b0 || ovf_o[k] !== 1'b0 || in_ready_o[k] !== 1'b1) begin
        n_err++; $display("FAIL midrst[%0d] got v=%b busy=%b ovf=%b rdy=%b exp 0/0/0/1", k, out_valid_o[k], busy_o[k], ovf_o[k], in_ready_o[k]); end
    end
    in_data = 32'h0d0c0b0a; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      n_vec++; if (out_valid_o[0] !== 1'b1 || out_index_o[0] !== 2'(b) || out_data_o[0] !== 8'(b + 10)) begin
        n_err++; $display("FAIL midrst_word%0d got v=%b i=%0d d=%h exp v=1 i=%0d d=%h", b, out_valid_o[0], out_index_o[0], out_data_o[0], b, 8'(b + 10)); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      for (int k = 0; k < 3; k++) begin
        n_vec++; if (in_ready_o[k] !== (vq[k].size() < 2) || busy_o[k] !== (vq[k].size() > 0) ||
                     out_valid_o[k] !== (vq[k].size() > 0) || ovf_o[k] !== ovf_m[k]) begin
          n_err++; $display("FAIL rnd_ctrl[%0d] cyc %0d got rdy=%b busy=%b v=%b ovf=%b exp %b/%b/%b/%b", k, i,
                            in_ready_o[k], busy_o[k], out_valid_o[k], ovf_o[k],
                            vq[k].size() < 2, vq[k].size() > 0, vq[k].size() > 0, ovf_m[k]); end
        if (vq[k].size() > 0) begin
          n_vec++; if (out_data_o[k] !== exp_word(k) || out_index_o[k] !== 2'(exp_idx(k)) || out_last_o[k] !== (pos[k] == nn[k] - 1)) begin
            n_err++; $display("FAIL rnd_beat[%0d] cyc %0d got d=%h i=%0d l=%b exp d=%h i=%0d l=%b", k, i,
                              out_data_o[k], out_index_o[k], out_last_o[k], exp_word(k), exp_idx(k), pos[k] == nn[k] - 1); end
        end
      end
      rst       = ($urandom_range(0, 149) == 0);
      in_valid  = ($urandom_range(0, 99) < ((i < 400) ? 20 : 60));
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      tick();
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    nn    = '{4, 4, 1};
    lsb_m = '{1'b1, 1'b0, 1'b1};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(negedge clk);
    tick();
    test_reset();
    test_word_order();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
